// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings common to transmitter and receiver,
// and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int unsigned CLK_PER_BIT_DEFAULT = 87;
    localparam int unsigned DATA_BITS           = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clk cycles and flags the last cycle of each bit period.
// The count restarts on i_clr or after the terminal count; it never relies on overflow.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned     CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clr || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shift register,
// so the next byte can be queued while the current frame is on the line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    uart_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        tick;
    logic        clr;
    logic        load;
    logic        done_pulse;

    // Handshake: a byte moves when i_valid and o_ready are both high on a clk edge;
    // o_ready comes straight from the holding-register flag, never from i_valid.
    assign o_ready = ~hold_full_q;
    assign o_tx    = tx_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_pulse;

    uart_baud_tick #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (clr),
        .o_tick(tick)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        load        = 1'b0;
        done_pulse  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    done_pulse = 1'b1;
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            bit_idx_d   = '0;
        end

        // Acceptance only when empty, so it never collides with a load on the same edge.
        if (i_valid && !hold_full_q) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end

        clr = (state_d != state_q) || (state_q == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timeline reference model checked every cycle, a serial
// decoder on o_tx fed from an expected-byte queue, plus table and corner sequences.
module tb_uart_tx;

    localparam int P     = 4;
    localparam int FRAME = 10 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_PER_BIT(P)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(i_valid),
        .i_data (i_data),
        .o_ready(o_ready),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is a 10-bit pattern played out over FRAME cycles.
    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [9:0] m_frame = 10'h3ff;
    logic [7:0] exp_q[$];

    // Serial decoder on the DUT line.
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    logic [9:0] rx_bits = 10'h0;
    int         rx_count = 0;
    int         done_count = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_tx();
        return m_active ? m_frame[m_pos / P] : 1'b1;
    endfunction

    task automatic start_frame();
        m_frame     = {1'b1, m_hold, 1'b0};
        m_pos       = 0;
        m_active    = 1'b1;
        m_hold_full = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = rst_n && i_valid && !m_hold_full;
        if (!rst_n) begin
            m_hold_full = 1'b0;
            m_active    = 1'b0;
            m_pos       = 0;
            exp_q.delete();
        end else begin
            if (m_active && m_pos == FRAME - 1) begin
                if (m_hold_full) start_frame();
                else m_active = 1'b0;
            end else if (m_active) begin
                m_pos++;
            end else if (m_hold_full) begin
                start_frame();
            end
            if (acc) begin
                m_hold      = i_data;
                m_hold_full = 1'b1;
                exp_q.push_back(i_data);
            end
        end
    endtask

    task automatic rx_step();
        if (!rx_busy) begin
            if (o_tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
            end
        end else begin
            rx_t++;
        end
        if (rx_busy && (rx_t % P) == P / 2) begin
            rx_bits[rx_t / P] = o_tx;
            if (rx_t / P == 9) begin
                rx_busy = 1'b0;
                rx_count++;
                chk("rx_start_bit", int'(rx_bits[0]), 0);
                chk("rx_stop_bit", int'(rx_bits[9]), 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_extra_byte: got %0h want none at %0t", rx_bits[8:1], $time);
                end else begin
                    chk("rx_byte", int'(rx_bits[8:1]), int'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // One clock: advance the model with the current inputs, then check at the falling edge.
    task automatic cycle();
        bit was_rst;
        was_rst = !rst_n;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("o_tx", int'(o_tx), int'(m_tx()));
        chk("o_busy", int'(o_busy), int'(m_active));
        chk("o_done", int'(o_done), int'(m_active && m_pos == FRAME - 1));
        chk("o_ready", int'(o_ready), int'(!m_hold_full));
        if (o_done) done_count++;
        if (was_rst) rx_busy = 1'b0;
        else rx_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [7:0] b, output int n);
        bit will_acc;
        bit ok;
        ok      = 1'b0;
        n       = 0;
        i_valid = 1'b1;
        i_data  = b;
        for (int i = 0; i < 200; i++) begin
            will_acc = !m_hold_full;
            cycle();
            n++;
            if (will_acc) begin
                ok = 1'b1;
                break;
            end
        end
        i_valid = 1'b0;
        chk("send_accepted", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!m_active && !m_hold_full && !rx_busy) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        chk("wait_idle", int'(ok), 1);
    endtask

    initial begin
        int n;
        int d0;
        int r0;
        int busy_run;
        int idx;
        bit ok;
        bit acc;
        logic [7:0] bp[3];

        vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
        vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
        vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
        vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};

        // Reset
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle(2);
        chk("reset_tx", int'(o_tx), 1);
        chk("reset_ready", int'(o_ready), 1);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        rst_n = 1'b1;

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            wait_idle();
            send(vecs[v].data, n);
            if (v == 0) chk("first_accept_latency", n, 1);
            chk("ready_low_after_accept", int'(o_ready), 0);
            for (int k = 1; k <= FRAME; k++) begin
                cycle();
                chk("frame_bit", int'(o_tx), int'(vecs[v].frame[(k - 1) / P]));
                if (k == 1) chk("ready_back_high", int'(o_ready), 1);
                if (k == FRAME - 1) chk("done_not_early", int'(o_done), 0);
                if (k == FRAME) chk("done_at_end", int'(o_done), 1);
            end
            cycle();
            chk("busy_after_frame", int'(o_busy), 0);
        end

        // Back-to-back frames: 0x00 then 0xFF queued while busy
        wait_idle();
        d0 = done_count;
        send(8'h00, n);
        i_valid  = 1'b1;
        i_data   = 8'hFF;
        busy_run = 0;
        for (int k = 1; k <= 200; k++) begin
            acc = i_valid && !m_hold_full;
            cycle();
            if (acc) i_valid = 1'b0;
            if (k == FRAME) chk("b2b_ready_last_stop", int'(o_ready), 0);
            if (k == FRAME + 1) begin
                chk("b2b_second_start", int'(o_tx), 0);
                chk("b2b_ready_after_load", int'(o_ready), 1);
            end
            if (o_busy) busy_run++;
            else break;
        end
        chk("b2b_busy_cycles", busy_run, 2 * FRAME);
        chk("b2b_done_pulses", done_count - d0, 2);

        // Backpressure: i_valid held high over three distinct bytes
        wait_idle();
        bp[0] = 8'h12; bp[1] = 8'h9E; bp[2] = 8'h47;
        d0 = done_count;
        r0 = rx_count;
        idx = 0;
        i_valid = 1'b1;
        i_data  = bp[0];
        for (int i = 0; i < 400 && idx < 3; i++) begin
            acc = !m_hold_full;
            cycle();
            if (acc) begin
                idx++;
                if (idx == 3) i_valid = 1'b0;
                else i_data = bp[idx];
            end
        end
        i_valid = 1'b0;
        wait_idle();
        chk("bp_frames", rx_count - r0, 3);
        chk("bp_done_pulses", done_count - d0, 3);
        chk("bp_queue_drained", exp_q.size(), 0);

        // Byte accepted on the very edge that ends STOP
        wait_idle();
        send(8'h5A, n);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_active && m_pos == FRAME - 1) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        chk("stopedge_reached", int'(ok), 1);
        i_valid = 1'b1;
        i_data  = 8'hC3;
        cycle();
        i_valid = 1'b0;
        chk("stopedge_idle_gap", int'(o_busy), 0);
        chk("stopedge_captured", int'(o_ready), 0);
        cycle();
        chk("stopedge_start", int'(o_tx), 0);
        chk("stopedge_busy", int'(o_busy), 1);
        wait_idle();

        // Mid-frame reset during data bit 3 of 0x3C with 0x81 queued
        send(8'h3C, n);
        send(8'h81, n);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_active && m_pos / P == 4) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        chk("midrst_reached_bit3", int'(ok), 1);
        chk("midrst_queued", int'(o_ready), 0);
        rst_n = 1'b0;
        cycle();
        chk("midrst_tx", int'(o_tx), 1);
        chk("midrst_ready", int'(o_ready), 1);
        chk("midrst_busy", int'(o_busy), 0);
        rst_n = 1'b1;
        d0 = done_count;
        r0 = rx_count;
        idle(3 * FRAME);
        chk("midrst_no_done", done_count - d0, 0);
        chk("midrst_no_frames", rx_count - r0, 0);

        // Random loopback: 256 bytes with random idle gaps
        d0 = done_count;
        r0 = rx_count;
        for (int i = 0; i < 256; i++) begin
            idle($urandom_range(0, 3));
            send(8'($urandom_range(0, 255)), n);
        end
        wait_idle();
        idle(2);
        chk("loop_done_pulses", done_count - d0, 256);
        chk("loop_bytes_received", rx_count - r0, 256);
        chk("loop_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
